// File: rtl/data_port_arbiter_pkg.sv
// Shared types for the data-port arbiter: sequencer states and requester IDs.
package data_port_arbiter_pkg;

    // 2'd3 is unused and steers back to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/data_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin chooser; a tie goes to the port not granted last.
module rr_pick2
    import data_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_CPU;
        case (req)
            2'b01:   grant_id = PORT_CPU;
            2'b10:   grant_id = PORT_AUX;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares one single-port DataMemory between the CPU data side (port 0) and an
// auxiliary master (port 1), with a fixed number of access wait cycles.
module data_port_arbiter
    import data_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_value,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_value,
    output logic              busy,
    output logic              owner
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              grant_valid, grant_id;

    rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Memory strobes are decoded from the state register, so an async reset drops them at once
    always_comb begin
        state_nxt       = state;
        mem_address     = '0;
        mem_write_value = '0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        m0_ack          = 1'b0;
        m1_ack          = 1'b0;
        busy            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                busy            = 1'b1;
                mem_address     = addr_q;
                mem_write_value = wdata_q;
                mem_read_en     = ~we_q;
                mem_write_en    = we_q && (cnt_q == 4'd0);
                if (cnt_q == 4'd0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                busy      = 1'b1;
                m0_ack    = (owner_q == PORT_CPU);
                m1_ack    = (owner_q == PORT_AUX);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_AUX;
            owner_q    <= PORT_CPU;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_id;
                        we_q    <= (grant_id == PORT_AUX) ? m1_we    : m0_we;
                        addr_q  <= (grant_id == PORT_AUX) ? m1_addr  : m0_addr;
                        wdata_q <= (grant_id == PORT_AUX) ? m1_wdata : m0_wdata;
                        cnt_q   <= CNT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (!we_q) begin
                            if (owner_q == PORT_AUX) rdata1_q <= mem_read_value;
                            else                     rdata0_q <= mem_read_value;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: last_grant <= owner_q;
                default: ;
            endcase
        end
    end

    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench: three arbiters (WAIT_CYCLES 1, 2, 3), each with its own memory model.
module tb_data_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req   [3][2];
    logic        we    [3][2];
    logic [31:0] addr  [3][2];
    logic [31:0] wdata [3][2];
    logic [31:0] rdata [3][2];
    logic        ack   [3][2];
    logic [31:0] maddr [3];
    logic [31:0] mwv   [3];
    logic [31:0] mrv   [3];
    logic        mwe   [3];
    logic        mre   [3];
    logic        busy  [3];
    logic        owner [3];
    logic [31:0] mem   [3][256];
    logic        wbit  [3][256];
    logic        mem_clr;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        data_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(k + 1)) dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req(req[k][0]), .m0_we(we[k][0]), .m0_addr(addr[k][0]),
            .m0_wdata(wdata[k][0]), .m0_rdata(rdata[k][0]), .m0_ack(ack[k][0]),
            .m1_req(req[k][1]), .m1_we(we[k][1]), .m1_addr(addr[k][1]),
            .m1_wdata(wdata[k][1]), .m1_rdata(rdata[k][1]), .m1_ack(ack[k][1]),
            .mem_address(maddr[k]), .mem_write_value(mwv[k]),
            .mem_write_en(mwe[k]), .mem_read_en(mre[k]), .mem_read_value(mrv[k]),
            .busy(busy[k]), .owner(owner[k])
        );
        // unwritten locations read as 0xA0000000 | addr
        assign mrv[k] = wbit[k][maddr[k][7:0]] ? mem[k][maddr[k][7:0]]
                                               : (32'hA000_0000 | 32'(maddr[k][7:0]));
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 256; a++) wbit[k][a] <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (mwe[k]) begin
                    mem[k][maddr[k][7:0]]  <= mwv[k];
                    wbit[k][maddr[k][7:0]] <= 1'b1;
                end
        end
    end

    // Drives one request on instance k, port p, starting at a negedge with the DUT idle.
    task automatic run_txn(input int k, input int p, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           output int ack_cyc, output int wr_cnt, output int wr_cyc,
                           output logic [31:0] wr_addr, output int rd_cnt,
                           output int rd_first, output int rd_last,
                           output logic [31:0] rd_val);
        ack_cyc = -1; wr_cnt = 0; wr_cyc = -1; wr_addr = '0;
        rd_cnt = 0; rd_first = -1; rd_last = -1; rd_val = '0;
        req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
        for (int i = 1; i <= 20 && ack_cyc < 0; i++) begin
            @(negedge clk);
            if (mwe[k]) begin wr_cnt++; wr_cyc = i; wr_addr = maddr[k]; end
            if (mre[k]) begin rd_cnt++; if (rd_first < 0) rd_first = i; rd_last = i; end
            if (ack[k][p]) begin ack_cyc = i; rd_val = rdata[k][p]; req[k][p] = 1'b0; end
        end
        req[k][p] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) req[k][p] = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({mwe[k], mre[k], busy[k], owner[k], ack[k][0], ack[k][1]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got we/re/busy/own/ack0/ack1=%b%b%b%b%b%b expected 000000",
                         k, mwe[k], mre[k], busy[k], owner[k], ack[k][0], ack[k][1]);
            end
            checks++;
            if ({maddr[k], mwv[k], rdata[k][0], rdata[k][1]} !== 128'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got addr=%h wv=%h rd0=%h rd1=%h expected all 0",
                         k, maddr[k], mwv[k], rdata[k][0], rdata[k][1]);
            end
        end
        for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) req[k][p] = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({mwe[k], mre[k]} !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_strobes[%0d] cyc %0d: got we=%b re=%b expected 0 0", k, i, mwe[k], mre[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int ac, wc, wcy, rc, rf, rl; logic [31:0] wa, rv;
        run_txn(0, 0, 1'b0, 32'h04, 32'h0, ac, wc, wcy, wa, rc, rf, rl, rv);
        checks++;
        if (rv !== 32'hA000_0004 || ac !== 2) begin
            errors++; $display("FAIL m0_read: got rdata=%h ack_cyc=%0d expected a0000004 2", rv, ac);
        end
        run_txn(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, ac, wc, wcy, wa, rc, rf, rl, rv);
        checks++;
        if (wc !== 1 || wcy !== 1 || wa !== 32'h10) begin
            errors++; $display("FAIL m0_write_strobe: got cnt=%0d cyc=%0d addr=%h expected 1 1 10", wc, wcy, wa);
        end
        checks++;
        if (ac !== 2) begin errors++; $display("FAIL m0_write_ack: got %0d expected 2", ac); end
        checks++;
        if (mem[0][8'h10] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL mem_written: got %h expected deadbeef", mem[0][8'h10]);
        end
        checks++;
        if (rdata[0][0] !== 32'hA000_0004) begin
            errors++; $display("FAIL m0_rdata_after_write: got %h expected a0000004", rdata[0][0]);
        end
        run_txn(0, 1, 1'b0, 32'h10, 32'h0, ac, wc, wcy, wa, rc, rf, rl, rv);
        checks++;
        if (rv !== 32'hDEAD_BEEF || ac !== 2) begin
            errors++; $display("FAIL m1_read: got rdata=%h ack_cyc=%0d expected deadbeef 2", rv, ac);
        end
        checks++;
        if (rdata[0][0] !== 32'hA000_0004) begin
            errors++; $display("FAIL m0_rdata_untouched: got %h expected a0000004", rdata[0][0]);
        end
    endtask

    task automatic test_contention();
        int n = 0; int cyc[4]; int who[4]; logic ownr[4]; logic [31:0] rv[4];
        int exp_who[4] = '{0, 1, 0, 1};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        we[0][0] = 1'b0; addr[0][0] = 32'h08;
        we[0][1] = 1'b0; addr[0][1] = 32'h0C;
        req[0][0] = 1'b1; req[0][1] = 1'b1;
        for (int i = 1; i <= 40 && n < 4; i++) begin
            @(negedge clk);
            if (ack[0][0] || ack[0][1]) begin
                cyc[n] = i; who[n] = ack[0][1] ? 1 : 0; ownr[n] = owner[0];
                rv[n] = ack[0][1] ? rdata[0][1] : rdata[0][0];
                n++;
            end
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        @(negedge clk);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL contention_count: got %0d acks expected 4", n); end
        for (int j = 0; j < n; j++) begin
            checks++;
            if (who[j] !== exp_who[j] || 32'(ownr[j]) !== exp_who[j]) begin
                errors++;
                $display("FAIL contention_order[%0d]: got ack port %0d owner %0d expected %0d", j, who[j], ownr[j], exp_who[j]);
            end
            checks++;
            if (rv[j] !== ((exp_who[j] == 1) ? 32'hA000_000C : 32'hA000_0008)) begin
                errors++; $display("FAIL contention_rdata[%0d]: got %h", j, rv[j]);
            end
            checks++;
            if (cyc[j] !== 2 + 3 * j) begin
                errors++; $display("FAIL contention_period[%0d]: got cycle %0d expected %0d", j, cyc[j], 2 + 3 * j);
            end
        end
    endtask

    task automatic test_wait_states();
        int ac, wc, wcy, rc, rf, rl; logic [31:0] wa, rv;
        run_txn(2, 1, 1'b0, 32'h20, 32'h0, ac, wc, wcy, wa, rc, rf, rl, rv);
        checks++;
        if (rc !== 3 || rf !== 1 || rl !== 3) begin
            errors++; $display("FAIL ws_read_en: got cnt=%0d first=%0d last=%0d expected 3 1 3", rc, rf, rl);
        end
        checks++;
        if (ac !== 4 || rv !== 32'hA000_0020) begin
            errors++; $display("FAIL ws_read_ack: got cyc=%0d rdata=%h expected 4 a0000020", ac, rv);
        end
        run_txn(2, 1, 1'b1, 32'h24, 32'h1234_5678, ac, wc, wcy, wa, rc, rf, rl, rv);
        checks++;
        if (wc !== 1 || wcy !== 3 || rc !== 0) begin
            errors++; $display("FAIL ws_write_en: got cnt=%0d cyc=%0d reads=%0d expected 1 3 0", wc, wcy, rc);
        end
        checks++;
        if (ac !== 4 || mem[2][8'h24] !== 32'h1234_5678) begin
            errors++; $display("FAIL ws_write_ack: got cyc=%0d mem=%h expected 4 12345678", ac, mem[2][8'h24]);
        end
    endtask

    task automatic test_reset_mid_write();
        int ac, wc, wcy, rc, rf, rl; logic [31:0] wa, rv;
        logic saw_we = 1'b0; logic saw_ack = 1'b0;
        req[2][0] = 1'b1; we[2][0] = 1'b1; addr[2][0] = 32'h30; wdata[2][0] = 32'hBAD0_BAD0;
        @(negedge clk);
        saw_we |= mwe[2];
        checks++;
        if (busy[2] !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy[2]); end
        @(negedge clk);
        saw_we |= mwe[2];
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || mwe[2] !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got busy=%b we=%b expected 0 0", busy[2], mwe[2]);
        end
        req[2][0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            saw_we |= mwe[2]; saw_ack |= ack[2][0];
        end
        checks++;
        if (saw_we !== 1'b0 || saw_ack !== 1'b0 || wbit[2][8'h30] !== 1'b0) begin
            errors++; $display("FAIL midrst_no_write: got we=%b ack=%b written=%b expected 0 0 0", saw_we, saw_ack, wbit[2][8'h30]);
        end
        run_txn(2, 0, 1'b0, 32'h30, 32'h0, ac, wc, wcy, wa, rc, rf, rl, rv);
        checks++;
        if (rv !== 32'hA000_0030 || ac !== 4) begin
            errors++; $display("FAIL midrst_readback: got %h cyc=%0d expected a0000030 4", rv, ac);
        end
    endtask

    task automatic test_field_latch();
        int ac = -1; int nacc = 0; logic bad = 1'b0;
        req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 32'h40;
        for (int i = 1; i <= 10 && ac < 0; i++) begin
            @(negedge clk);
            if (mre[1]) begin nacc++; if (maddr[1] !== 32'h40) bad = 1'b1; end
            if (i == 1) addr[1][0] = 32'h44;
            if (ack[1][0]) begin
                ac = i; req[1][0] = 1'b0;
                checks++;
                if (rdata[1][0] !== 32'hA000_0040) begin
                    errors++; $display("FAIL latch_rdata: got %h expected a0000040", rdata[1][0]);
                end
            end
        end
        req[1][0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bad || nacc !== 2 || ac !== 3) begin
            errors++; $display("FAIL latch_addr: got bad=%b access=%0d ack_cyc=%0d expected 0 2 3", bad, nacc, ac);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_clr = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 1'b0; we[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0;
            end
        @(negedge clk);
        mem_clr = 1'b0;
        test_reset();
        test_write_read();
        test_contention();
        test_wait_states();
        test_reset_mid_write();
        test_field_latch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
